lsu_dmem_master: RTL and testbench

//  Initiator side of the word-wide data-memory port: accepts load/store requests from the MEM stage,

---
 rtl/lsu_dmem_master.sv | 137 +++++++++++++
 tb/tb_lsu_dmem_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: initiator side of the word-wide data-memory port.
// Accepts one load/store at a time from the MEM stage, performs the memory
// access in a single cycle (read-modify-write for byte/half stores) and
// presents the result until the consumer takes it.
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned half/word
// accesses instead of silently using the aligned word.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1; valid, once raised, holds its payload stable until that edge.
module lsu_dmem_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misalign,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              op_we;
    logic [1:0]        op_size;
    logic              op_unsigned;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;

    logic              misalign;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;

    // State register; reset drops any in-flight operation immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: accept in IDLE, one access cycle, hold response until taken
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_valid) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; the write strobe exists only in ACCESS
    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
        mem_we    = (state == S_ACCESS) && op_we && !misalign;
    end

    // Latch the request payload on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_we       <= 1'b0;
            op_size     <= 2'b00;
            op_unsigned <= 1'b0;
            op_addr     <= '0;
            op_wdata    <= 32'd0;
        end else if (state == S_IDLE && req_valid) begin
            op_we       <= req_we;
            op_size     <= req_size;
            op_unsigned <= req_unsigned;
            op_addr     <= req_addr;
            op_wdata    <= req_wdata;
        end
    end

    // Misaligned-access detection (half needs addr[0]=0, word needs addr[1:0]=0)
    always_comb begin
`ifdef MISALIGN_TRAP_EN
        misalign = ((op_size == 2'b01) && op_addr[0]) ||
                   (op_size[1] && (op_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Lane extraction for loads and lane merge for stores (little-endian)
    always_comb begin
        byte_lane = mem_rdata[{op_addr[1:0], 3'b000} +: 8];
        half_lane = mem_rdata[{op_addr[1], 4'b0000} +: 16];
        case (op_size)
            2'b00:   load_val = {{24{byte_lane[7] & ~op_unsigned}}, byte_lane};
            2'b01:   load_val = {{16{half_lane[15] & ~op_unsigned}}, half_lane};
            default: load_val = mem_rdata;
        endcase
        merge_val = mem_rdata;
        case (op_size)
            2'b00:   merge_val[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
            2'b01:   merge_val[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
            default: merge_val = op_wdata;
        endcase
    end

    // Capture the response at the end of the access cycle; held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata    <= 32'd0;
            rsp_misalign <= 1'b0;
        end else if (state == S_ACCESS) begin
            rsp_rdata    <= (op_we || misalign) ? 32'd0 : load_val;
            rsp_misalign <= misalign;
        end
    end

    assign mem_raddr = {op_addr[ADDR_W-1:2], 2'b00};
    assign mem_waddr = {op_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata = merge_val;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: table-driven directed vectors, reset/stall sequences
// and randomized traffic checked against an arithmetic reference model.
module tb_lsu_dmem_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    int tests = 0;
    int fails = 0;

    lsu_dmem_master #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // word-only memory: combinational read, synchronous write
    assign mem_rdata = mem[mem_raddr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_waddr[7:2]] <= mem_wdata;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: rules from the behaviour, plain arithmetic
    function automatic bit ref_mis(input logic [1:0] size, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        if (size == 2'b01) return addr[0];
        if (size >= 2'b10) return addr[1:0] != 2'b00;
`endif
        return 1'b0;
    endfunction

    function automatic int lane_off(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b00) return int'(addr % 4);
        if (size == 2'b01) return int'((addr / 2) % 2) * 2;
        return 0;
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        if (size == 2'b00) return 32'h0000_00FF;
        if (size == 2'b01) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
        logic [31:0] v;
        logic [31:0] m;
        if (ref_mis(size, addr)) return 32'd0;
        m = size_mask(size);
        v = (word >> (8 * lane_off(size, addr))) & m;
        if (!uns && m != 32'hFFFF_FFFF && (v & ((m >> 1) + 1)) != 0) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] m;
        int sh;
        if (ref_mis(size, addr)) return word;
        m  = size_mask(size);
        sh = 8 * lane_off(size, addr);
        return (word & ~(m << sh)) | ((wd & m) << sh);
    endfunction

    // driver: issue one op from a negedge with req_ready=1, return at a negedge
    // after the response is consumed; checks handshake timing along the way
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int stall,
                          output logic [31:0] rdata, output logic mis, output int lat,
                          output int we_cnt, output logic [31:0] wdata_seen);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        rsp_ready = (stall == 0);
        lat = 0; we_cnt = 0; wdata_seen = 32'd0;
        do begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            req_we = $urandom_range(0, 1);
            req_addr = $urandom;
            lat++;
            if (mem_we) begin
                we_cnt++;
                wdata_seen = mem_wdata;
            end
            if (!rsp_valid) check("req_ready_low_access", {31'd0, req_ready}, 32'd0);
        end while (!rsp_valid && lat < 10);
        check("rsp_latency", lat, 2);
        rdata = rsp_rdata;
        mis   = rsp_misalign;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rsp_rdata", rsp_rdata, rdata);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            if (mem_we) we_cnt++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("rsp_done_ready", {31'd0, req_ready}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] init;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] init, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] er, input logic em, input logic [31:0] ew);
        vec_t v;
        v.init = init; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wd; v.exp_rdata = er; v.exp_mis = em; v.exp_word = ew;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] wseen;
        logic        mis;
        int          lat;
        int          wec;
        int          idx;
        logic [1:0]  sz;
        logic        we;
        logic        uns;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] er;
        logic        em;

        // reset state
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        @(negedge clk);
        @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_misalign", {31'd0, rsp_misalign}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed table
        vecs.push_back(mk(32'h11223344, 1, 2'b00, 0, 32'h102, 32'h000000AA, 32'h0, 0, 32'h11AA3344));
        vecs.push_back(mk(32'h11223344, 1, 2'b00, 0, 32'h103, 32'h12345655, 32'h0, 0, 32'h55223344));
        vecs.push_back(mk(32'h8000F0FF, 0, 2'b00, 0, 32'h100, 32'h0, 32'hFFFFFFFF, 0, 32'h8000F0FF));
        vecs.push_back(mk(32'h8000F0FF, 0, 2'b00, 1, 32'h100, 32'h0, 32'h000000FF, 0, 32'h8000F0FF));
        vecs.push_back(mk(32'h8000F0FF, 0, 2'b01, 0, 32'h102, 32'h0, 32'hFFFF8000, 0, 32'h8000F0FF));
        vecs.push_back(mk(32'h8000F0FF, 0, 2'b01, 1, 32'h100, 32'h0, 32'h0000F0FF, 0, 32'h8000F0FF));
        vecs.push_back(mk(32'h8000F0FF, 0, 2'b00, 0, 32'h101, 32'h0, 32'hFFFFFFF0, 0, 32'h8000F0FF));
        vecs.push_back(mk(32'h8000F0FF, 0, 2'b00, 1, 32'h103, 32'h0, 32'h00000080, 0, 32'h8000F0FF));
        vecs.push_back(mk(32'h11223344, 1, 2'b01, 0, 32'h100, 32'h1234ABCD, 32'h0, 0, 32'h1122ABCD));
        vecs.push_back(mk(32'hCAFEF00D, 0, 2'b11, 0, 32'h104, 32'h0, 32'hCAFEF00D, 0, 32'hCAFEF00D));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk(32'h11223344, 1, 2'b01, 0, 32'h101, 32'h0000BEEF, 32'h0, 1, 32'h11223344));
        vecs.push_back(mk(32'hCAFEF00D, 0, 2'b10, 0, 32'h106, 32'h0, 32'h0, 1, 32'hCAFEF00D));
`else
        vecs.push_back(mk(32'h11223344, 1, 2'b01, 0, 32'h101, 32'h0000BEEF, 32'h0, 0, 32'h1122BEEF));
        vecs.push_back(mk(32'hCAFEF00D, 0, 2'b10, 0, 32'h106, 32'h0, 32'hCAFEF00D, 0, 32'hCAFEF00D));
`endif
        foreach (vecs[i]) begin
            idx = int'(vecs[i].addr[7:2]);
            mem[idx] = vecs[i].init;
            run_op(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   i % 3, rd, mis, lat, wec, wseen);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_misalign", i), {31'd0, mis}, {31'd0, vecs[i].exp_mis});
            check($sformatf("vec%0d_word", i), mem[idx], vecs[i].exp_word);
            check($sformatf("vec%0d_we_cycles", i), wec,
                  (vecs[i].we && !vecs[i].exp_mis) ? 1 : 0);
            if (vecs[i].we && !vecs[i].exp_mis)
                check($sformatf("vec%0d_wdata", i), wseen, vecs[i].exp_word);
        end

        // st.w then ld.w, with a 5-cycle response stall on the load
        run_op(1'b1, 2'b10, 1'b0, 32'h108, 32'hDEADBEEF, 0, rd, mis, lat, wec, wseen);
        check("stw_rdata", rd, 32'd0);
        run_op(1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 5, rd, mis, lat, wec, wseen);
        check("ldw_after_stw", rd, 32'hDEADBEEF);
        mem[1] = 32'h0BADF00D;
        run_op(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 5, rd, mis, lat, wec, wseen);
        check("ldw_stalled", rd, 32'h0BADF00D);

        // reset in the middle of a st.w access cycle
        mem[3] = 32'h01020304;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10C; req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_we_before", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_word", mem[3], 32'h01020304);
        rst = 1'b0;
        @(negedge clk);

        // randomized traffic against the reference model
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int n = 0; n < 60; n++) begin
            we  = $urandom_range(0, 1);
            sz  = 2'($urandom_range(0, 3));
            uns = $urandom_range(0, 1);
            ad  = 32'($urandom_range(0, 255));
            wd  = $urandom;
            idx = int'(ad[7:2]);
            em  = ref_mis(sz, ad);
            er  = we ? 32'd0 : ref_load(ref_mem[idx], sz, uns, ad);
            if (we) ref_mem[idx] = ref_store(ref_mem[idx], sz, ad, wd);
            run_op(we, sz, uns, ad, wd, $urandom_range(0, 2), rd, mis, lat, wec, wseen);
            check($sformatf("rnd%0d_rdata", n), rd, er);
            check($sformatf("rnd%0d_misalign", n), {31'd0, mis}, {31'd0, em});
            check($sformatf("rnd%0d_word", n), mem[idx], ref_mem[idx]);
            check($sformatf("rnd%0d_we_cycles", n), wec, (we && !em) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
